// File: rtl/ika2151_channel_acc.sv
// Channel accumulator: sums each channel's carrier outputs over a 32-slot frame,
// substitutes noise on slot 31, saturates to OUT_W bits and emits one L/R word per channel.
module ika2151_channel_acc #(
    parameter int ACC_W = 18,
    parameter int OUT_W = 16
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_MRST,
    input  logic                    i_phi1_NCEN_n,
    input  logic                    i_CYCLE_31,
    input  logic signed [13:0]      i_OP_DATA,
    input  logic [2:0]              i_CONNECT,
    input  logic                    i_NE,
    input  logic signed [13:0]      i_ACC_NOISE,
    input  logic [1:0]              i_RL,
    output logic signed [OUT_W-1:0] o_CH_L,
    output logic signed [OUT_W-1:0] o_CH_R,
    output logic [2:0]              o_CH_NUM,
    output logic                    o_CH_VALID,
    output logic                    o_CLIP,
    output logic                    o_SYNCED
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [4:0]              cnt;
    logic [4:0]              slot;
    logic [2:0]              ch;
    logic [1:0]              grp;
    logic                    carrier;
    logic                    synced_next;
    logic                    saturated;
    logic signed [13:0]      d_raw;
    logic signed [ACC_W-1:0] operand;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] sat_sum;
    logic signed [ACC_W-1:0] acc [8];

    // The cycle-31 pulse forces the slot so a resync lands on ch7 C2 immediately.
    assign slot        = i_CYCLE_31 ? 5'd31 : cnt;
    assign ch          = slot[2:0];
    assign grp         = slot[4:3];
    assign synced_next = o_SYNCED | i_CYCLE_31;

    always_comb begin
        carrier = 1'b0;
        case (grp)
            2'd0:    carrier = (i_CONNECT == 3'd7);
            2'd1:    carrier = (i_CONNECT >= 3'd5);
            2'd2:    carrier = (i_CONNECT >= 3'd4);
            default: carrier = 1'b1;
        endcase
    end

    assign d_raw   = (slot == 5'd31 && i_NE) ? i_ACC_NOISE : i_OP_DATA;
    assign operand = carrier ? {{(ACC_W - 14){d_raw[13]}}, d_raw} : '0;
    assign sum     = acc[ch] + operand;

    always_comb begin
        saturated = 1'b1;
        if (sum > SAT_MAX) begin
            sat_sum = SAT_MAX[OUT_W-1:0];
        end else if (sum < SAT_MIN) begin
            sat_sum = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_sum   = sum[OUT_W-1:0];
            saturated = 1'b0;
        end
    end

    // C2 slots read the channel sum out; earlier groups restart or extend it.
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            cnt        <= '0;
            o_CH_L     <= '0;
            o_CH_R     <= '0;
            o_CH_NUM   <= '0;
            o_CH_VALID <= 1'b0;
            o_CLIP     <= 1'b0;
            o_SYNCED   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                acc[i] <= '0;
            end
        end else if (!i_phi1_NCEN_n) begin
            cnt      <= i_CYCLE_31 ? 5'd0 : cnt + 5'd1;
            o_SYNCED <= synced_next;
            if (grp == 2'd3) begin
                o_CH_L     <= i_RL[0] ? sat_sum : '0;
                o_CH_R     <= i_RL[1] ? sat_sum : '0;
                o_CH_NUM   <= ch;
                o_CH_VALID <= synced_next;
                o_CLIP     <= saturated & synced_next;
            end else begin
                o_CH_VALID <= 1'b0;
                o_CLIP     <= 1'b0;
                acc[ch]    <= (grp == 2'd0) ? operand : sum;
            end
        end
    end

endmodule
